// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_XOR  = 11'b11001010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Memory ops use the ALU purely for address add.
  localparam logic [2:0] ALU_MEM = 3'b000;

  typedef struct packed {
    logic       alusrc;
    logic       reg2loc;
    logic [2:0] aluop;
    logic       memtoreg;
    logic       is_mem;
    logic       is_store;
  } dec_t;

  typedef struct packed {
    logic pc_wen;
    logic ir_wen;
    logic wen;
    logic mem_req;
    logic memwrite;
    logic busy;
  } strobe_t;

  // Strobe pattern shown while the FSM sits in state s.
  function automatic strobe_t strobes_for(state_t s, logic is_store);
    strobe_t st;
    st = '0;
    case (s)
      ST_FETCH: begin
        st.pc_wen = 1'b1;
        st.ir_wen = 1'b1;
        st.busy   = 1'b1;
      end
      ST_DECODE, ST_EXEC: st.busy = 1'b1;
      ST_MEM: begin
        st.mem_req  = 1'b1;
        st.memwrite = is_store;
        st.busy     = 1'b1;
      end
      ST_WB: begin
        st.wen  = 1'b1;
        st.busy = 1'b1;
      end
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Handshake and control bundle between the instruction side and the sequencer.
interface multicycle_sequencer_if #(parameter int CNT_W = 16);
  logic             run;
  logic [10:0]      opcode;
  logic             mem_ack;
  logic             pc_wen;
  logic             ir_wen;
  logic             wen_cntrl;
  logic             alusrc_cntrl;
  logic             reg2loc_cntrl;
  logic             memtoreg_cntrl;
  logic [2:0]       aluop_cntrl;
  logic             mem_req;
  logic             memwrite_cntrl;
  logic             busy;
  logic [CNT_W-1:0] retired;

  modport master (
    output run, opcode, mem_ack,
    input  pc_wen, ir_wen, wen_cntrl, alusrc_cntrl, reg2loc_cntrl,
           memtoreg_cntrl, aluop_cntrl, mem_req, memwrite_cntrl, busy, retired
  );

  modport slave (
    input  run, opcode, mem_ack,
    output pc_wen, ir_wen, wen_cntrl, alusrc_cntrl, reg2loc_cntrl,
           memtoreg_cntrl, aluop_cntrl, mem_req, memwrite_cntrl, busy, retired
  );
endinterface

// File: rtl/multicycle_sequencer_seq_decode.sv
// Combinational opcode decode into static datapath controls.
module seq_decode
  import multicycle_sequencer_pkg::*;
(
  input  logic [10:0] opcode,
  output dec_t        dec
);

  // Loads/stores get the immediate ALU path; everything else is treated as R-type.
  always_comb begin
    dec          = '0;
    dec.aluop    = opcode[2:0];
    dec.memtoreg = 1'b1;
    case (opcode)
      OP_LDUR: begin
        dec.alusrc   = 1'b1;
        dec.aluop    = ALU_MEM;
        dec.memtoreg = 1'b0;
        dec.is_mem   = 1'b1;
      end
      OP_STUR: begin
        dec.alusrc   = 1'b1;
        dec.reg2loc  = 1'b1;
        dec.aluop    = ALU_MEM;
        dec.memtoreg = 1'b0;
        dec.is_mem   = 1'b1;
        dec.is_store = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FSM, latched static controls, retire counter.
//   state  | meaning
//   IDLE   | waiting for run
//   FETCH  | PC increment + IR load
//   DECODE | static controls captured at end of cycle
//   EXEC   | ALU cycle, no strobes
//   MEM    | data-memory request held until ack
//   WB     | register-file write, retire
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_sequencer_if.slave  bus
);

  state_t           state, next_state;
  strobe_t          strb;
  dec_t             dec;
  dec_t             ctl;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  seq_decode u_decode (
    .opcode (bus.opcode),
    .dec    (dec)
  );

  // Next-state selection; run is only looked at in IDLE and at retire.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   next_state = bus.run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = ctl.is_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (bus.mem_ack) begin
          if (ctl.is_store) next_state = bus.run ? ST_FETCH : ST_IDLE;
          else              next_state = ST_WB;
        end
      end
      ST_WB:     next_state = bus.run ? ST_FETCH : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign retire = (state == ST_WB) || (state == ST_MEM && bus.mem_ack && ctl.is_store);

  // State register with strobes pre-computed from the next state, so they come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      strb  <= '0;
    end else begin
      state <= next_state;
      strb  <= strobes_for(next_state, ctl.is_store);
    end
  end

  // Static controls captured once per instruction on the DECODE->EXEC edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ctl <= '0;
    else if (state == ST_DECODE) ctl <= dec;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end

  assign bus.pc_wen         = strb.pc_wen;
  assign bus.ir_wen         = strb.ir_wen;
  assign bus.wen_cntrl      = strb.wen;
  assign bus.mem_req        = strb.mem_req;
  assign bus.memwrite_cntrl = strb.memwrite;
  assign bus.busy           = strb.busy;
  assign bus.alusrc_cntrl   = ctl.alusrc;
  assign bus.reg2loc_cntrl  = ctl.reg2loc;
  assign bus.aluop_cntrl    = ctl.aluop;
  assign bus.memtoreg_cntrl = ctl.memtoreg;
  assign bus.retired        = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer against a per-instruction cycle model.
module tb_multicycle_sequencer;

  localparam int CNT_W = 4;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDI = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] XORI = 11'b11001010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;

  logic clk = 1'b0;
  logic rst;

  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multicycle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: retired instructions since last reset, and the controls last decoded.
  int         exp_count = 0;
  logic       exp_alusrc = 1'b0;
  logic       exp_reg2loc = 1'b0;
  logic [2:0] exp_aluop = 3'b000;
  logic       exp_memtoreg = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Static controls implied by an opcode.
  task automatic model_decode(input logic [10:0] op);
    if (op == LDUR || op == STUR) begin
      exp_alusrc   = 1'b1;
      exp_reg2loc  = (op == STUR);
      exp_aluop    = 3'b000;
      exp_memtoreg = 1'b0;
    end else begin
      exp_alusrc   = 1'b0;
      exp_reg2loc  = 1'b0;
      exp_aluop    = op[2:0];
      exp_memtoreg = 1'b1;
    end
  endtask

  task automatic check_cycle(input string tag, input bit pc, input bit ir, input bit wen,
                             input bit req, input bit mw, input bit bsy);
    logic [CNT_W-1:0] r;
    r = CNT_W'(exp_count % (1 << CNT_W));
    check({tag, ".pc_wen"},   32'(bus.pc_wen),         32'(pc));
    check({tag, ".ir_wen"},   32'(bus.ir_wen),         32'(ir));
    check({tag, ".wen"},      32'(bus.wen_cntrl),      32'(wen));
    check({tag, ".mem_req"},  32'(bus.mem_req),        32'(req));
    check({tag, ".memwrite"}, 32'(bus.memwrite_cntrl), 32'(mw));
    check({tag, ".busy"},     32'(bus.busy),           32'(bsy));
    check({tag, ".alusrc"},   32'(bus.alusrc_cntrl),   32'(exp_alusrc));
    check({tag, ".reg2loc"},  32'(bus.reg2loc_cntrl),  32'(exp_reg2loc));
    check({tag, ".aluop"},    32'(bus.aluop_cntrl),    32'(exp_aluop));
    check({tag, ".memtoreg"}, 32'(bus.memtoreg_cntrl), 32'(exp_memtoreg));
    check({tag, ".retired"},  32'(bus.retired),        32'(r));
  endtask

  // Entered at a negedge where the DUT shows FETCH; leaves at the next FETCH (run_next=1) or IDLE.
  task automatic do_instr(input logic [10:0] op, input int dly, input bit run_next);
    bit is_mem, is_st;
    is_mem = (op == LDUR) || (op == STUR);
    is_st  = (op == STUR);
    check_cycle("fetch", 1, 1, 0, 0, 0, 1);
    bus.opcode  = op;
    bus.run     = 1'($urandom);
    bus.mem_ack = 1'($urandom);
    @(negedge clk);
    check_cycle("decode", 0, 0, 0, 0, 0, 1);
    model_decode(op);
    bus.run     = 1'($urandom);
    bus.mem_ack = 1'($urandom);
    @(negedge clk);
    check_cycle("exec", 0, 0, 0, 0, 0, 1);
    bus.opcode  = 11'($urandom);
    bus.run     = 1'($urandom);
    bus.mem_ack = 1'($urandom);
    if (is_mem) begin
      for (int k = 0; k <= dly; k++) begin
        @(negedge clk);
        check_cycle("mem", 0, 0, 0, 1, is_st, 1);
        bus.mem_ack = (k == dly);
        bus.run     = (is_st && k == dly) ? run_next : 1'($urandom);
      end
    end
    if (!is_st) begin
      @(negedge clk);
      check_cycle("wb", 0, 0, 1, 0, 0, 1);
      bus.run     = run_next;
      bus.mem_ack = 1'($urandom);
    end
    exp_count++;
    @(negedge clk);
    bus.mem_ack = 1'($urandom);
    if (!run_next) check_cycle("idle", 0, 0, 0, 0, 0, 0);
  endtask

  // Sit in IDLE for n cycles, then raise run; leaves at the negedge showing FETCH.
  task automatic idle_then_start(input int n);
    for (int i = 0; i < n; i++) begin
      bus.run     = 1'b0;
      bus.mem_ack = 1'($urandom);
      @(negedge clk);
      check_cycle("idle_hold", 0, 0, 0, 0, 0, 0);
    end
    bus.run = 1'b1;
    @(negedge clk);
  endtask

  // Abandon an LDUR in MEM with an asynchronous reset, then restart.
  task automatic reset_mid_mem();
    check_cycle("rfetch", 1, 1, 0, 0, 0, 1);
    bus.opcode  = LDUR;
    bus.mem_ack = 1'b0;
    bus.run     = 1'b1;
    @(negedge clk);
    model_decode(LDUR);
    @(negedge clk);
    @(negedge clk);
    check_cycle("rmem1", 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    check_cycle("rmem2", 0, 0, 0, 1, 0, 1);
    #2 rst = 1'b1;
    #1;
    exp_count    = 0;
    exp_alusrc   = 1'b0;
    exp_reg2loc  = 1'b0;
    exp_aluop    = 3'b000;
    exp_memtoreg = 1'b0;
    check_cycle("async_rst", 0, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check_cycle("in_rst", 0, 0, 0, 0, 0, 0);
    rst     = 1'b0;
    bus.run = 1'b0;
    @(negedge clk);
    check_cycle("late_ack", 0, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b0;
    bus.run     = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [10:0] pick_op();
    case ($urandom_range(0, 7))
      0: return ADD;
      1: return SUB;
      2: return ANDI;
      3: return ORR;
      4: return XORI;
      5: return LDUR;
      6: return STUR;
      default: return 11'($urandom);
    endcase
  endfunction

  initial begin
    rst         = 1'b1;
    bus.run     = 1'b0;
    bus.opcode  = 11'h000;
    bus.mem_ack = 1'b0;
    #1;
    check_cycle("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check_cycle("post_reset", 0, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b0;
    bus.run     = 1'b1;
    @(negedge clk);

    do_instr(ADD, 0, 1'b1);
    do_instr(LDUR, 2, 1'b1);
    do_instr(STUR, 0, 1'b1);
    do_instr(11'h7FF, 0, 1'b1);
    do_instr(SUB, 0, 1'b0);
    idle_then_start(3);
    reset_mid_mem();

    for (int i = 0; i < 40; i++) begin
      bit rn;
      rn = (i == 39) ? 1'b1 : ($urandom_range(0, 3) != 0);
      do_instr(pick_op(), $urandom_range(0, 3), rn);
      if (!rn) idle_then_start($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the single-issue datapath. It walks each instruction through fetch, decode, execute, memory and write-back. It latches the static datapath controls (ALU source, register-2 select, ALU op, write-back select) once per instruction and generates the per-cycle strobes: PC/IR load, register-file write, and data-memory request/write. It sits between the instruction register and the datapath, and owns the req/ack handshake with data memory.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  enables sequencing; sampled in IDLE and at every instruction boundary.
- `opcode`  in  11  opcode field from the instruction register; valid from DECODE onward.
- `mem_ack`  in  1  data memory completes the current request; ignored outside MEM.
- `pc_wen`, `ir_wen`  out  1  PC increment and IR load strobes.
- `wen_cntrl`  out  1  register-file write strobe.
- `alusrc_cntrl`, `reg2loc_cntrl`, `memtoreg_cntrl`  out  1  latched static controls.
- `aluop_cntrl`  out  3  latched ALU operation.
- `mem_req`  out  1  data-memory request, held until acknowledged.
- `memwrite_cntrl`  out  1  write qualifier for `mem_req`.
- `busy`  out  1  high in every state except IDLE.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: go to FETCH when `run`=1, otherwise stay in IDLE.
- FETCH: assert `pc_wen`=1 and `ir_wen`=1 for one cycle, then go to DECODE.
- DECODE: latch the static controls from `opcode`, then go to EXEC.
  - R-type (`ADD`, `SUB`, `AND`, `XOR`, `ORR`): alusrc=0, reg2loc=0, aluop=opcode[2:0], memtoreg=1.
  - `LDUR`: alusrc=1, reg2loc=0, aluop=000, memtoreg=0.
  - `STUR`: alusrc=1, reg2loc=1, aluop=000, memtoreg=0.
  - Any other opcode: decoded as R-type.
  - memtoreg=1 selects the ALU result; memtoreg=0 selects memory data.
- EXEC: one cycle, no strobes. Next state is MEM for `LDUR`/`STUR`, otherwise WB.
- MEM: `mem_req`=1 every cycle until `mem_ack`. `memwrite_cntrl`=1 only in MEM and only for `STUR`.
  - On `mem_ack` for `LDUR`: go to WB.
  - On `mem_ack` for `STUR`: the instruction retires and the next state is the boundary choice.
- WB: `wen_cntrl`=1 for exactly one cycle; the instruction retires; next state is the boundary choice.
- Boundary choice: go to FETCH if `run`=1, otherwise IDLE. `run` is never sampled mid-instruction.
- `retired` increments by 1 on each retire and wraps from 2^CNT_W−1 to 0.
- `STUR` never asserts `wen_cntrl`.

## Timing
- Strobes (`pc_wen`, `ir_wen`, `wen_cntrl`, `mem_req`, `memwrite_cntrl`, `busy`) are Moore outputs of the state register, glitch-free from flops.
- Static controls change only on the DECODE→EXEC edge and hold until the next DECODE.
- Latency from FETCH to the retire edge, with ack on the first MEM cycle:
  - R-type: 4 cycles.
  - `STUR`: 4 cycles.
  - `LDUR`: 5 cycles.
  - Each extra MEM wait cycle adds 1.
- Back-to-back: with `run` held high, the next FETCH immediately follows WB or the `STUR` ack cycle.
- `mem_ack` asserted in any state other than MEM has no effect.
- Asynchronous `rst` at any time:
  - State goes to IDLE.
  - All strobes and static controls go to 0; `aluop_cntrl`=000.
  - `retired` goes to 0.
  - Any pending memory request is abandoned; `mem_req` drops within the reset assertion, not at the next edge.
- Release from reset: the first FETCH comes one cycle after the first edge that samples `run`=1.

## Structure
- Add to `define.v`: the six state encodings (3-bit) and the memory-op ALU code (3'b000), alongside the existing opcode macros.
- One sub-module, `seq_decode`: combinational opcode→{alusrc, reg2loc, aluop, memtoreg, is_mem, is_store}. The sequencer registers its outputs in DECODE.
- The sequencer keeps the FSM, control latches and counter.

## Test plan
- Reset, then `run`=1 with `opcode`=`ADD` -> `pc_wen`/`ir_wen` in cycle 1; `wen_cntrl`=1 in cycle 4 only; aluop=opcode[2:0], memtoreg=1, `retired`=1.
- `LDUR`, `mem_ack` delayed 3 cycles -> `mem_req` high 3 cycles with `memwrite_cntrl`=0; then WB with `wen_cntrl`=1, memtoreg=0, alusrc=1; total 7 cycles.
- `STUR`, ack on the first MEM cycle -> `memwrite_cntrl`=1 for 1 cycle; reg2loc=1; `wen_cntrl` never high; next FETCH at cycle 5.
- Undefined opcode 11'h7FF -> R-type path; aluop=3'b111; `wen_cntrl` pulse in cycle 4.
- `rst` pulsed mid-MEM of `LDUR` -> `mem_req`, `busy` and `retired` go to 0 asynchronously; a later `mem_ack` is ignored; restart fetches cleanly.
- `run` dropped during EXEC of `SUB` -> the instruction completes; state returns to IDLE after WB; with CNT_W=4 and 16 retires, `retired` wraps to 0.
